tile_scan_ctrl: RTL and testbench

//  Sequencer for the per-tile image engines (compression, encoding).
//  - Walks the IMG_DIM x IMG_DIM pixel image in TILE x TILE tiles, raster order.
//  - For each tile: drives row/col to load it into the engine, hands off via eng_start/eng_done, then drives write-back addresses and out_we.
//  - Replaces hand-written load/compute/store loops inside each engine with one shared scan controller.

---
 rtl/tile_scan_if.sv | 28 ++
 rtl/tile_scan_ctrl.sv | 73 +++++++
 tb/tb_tile_scan_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/tile_scan_if.sv
// tile_scan_if: handshake and address bus between the tile scan controller and an image engine
interface tile_scan_if #(
  parameter int AW = 6,
  parameter int KW = 4,
  parameter int TW = 8
);
  logic          start;
  logic          wb_en;
  logic          eng_done;
  logic [AW-1:0] row;
  logic [AW-1:0] col;
  logic          ld_en;
  logic [KW-1:0] ld_idx;
  logic          eng_start;
  logic          out_we;
  logic [KW-1:0] wb_idx;
  logic [TW-1:0] tile_idx;
  logic          busy;
  logic          done;
  modport master (
    input  start, wb_en, eng_done,
    output row, col, ld_en, ld_idx, eng_start, out_we, wb_idx, tile_idx, busy, done
  );
  modport slave (
    output start, wb_en, eng_done,
    input  row, col, ld_en, ld_idx, eng_start, out_we, wb_idx, tile_idx, busy, done
  );
endinterface

// File: rtl/tile_scan_ctrl.sv
// tile_scan_ctrl: raster tile walker driving load, engine handoff and write-back of each tile
module tile_scan_ctrl #(
  parameter int IMG_DIM = 64,
  parameter int TILE    = 4,
  parameter int AW      = 6,
  parameter int KW      = 4,
  parameter int TW      = 8
) (
  input logic         clk,
  input logic         rst_n,
  tile_scan_if.master bus
);
  localparam int TB = $clog2(IMG_DIM / TILE);
  localparam int LT = $clog2(TILE);
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, WRITE, NEXT, DONE} state_t;
  state_t        state, state_n;
  logic [KW-1:0] k, k_n;
  logic [TW-1:0] tile, tile_n;
  logic          wb, wb_n;
  logic          act;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      k     <= '0;
      tile  <= '0;
      wb    <= 1'b0;
    end else begin
      state <= state_n;
      k     <= k_n;
      tile  <= tile_n;
      wb    <= wb_n;
    end
  end
  always_comb begin
    state_n = state;
    k_n     = k;
    tile_n  = tile;
    wb_n    = wb;
    case (state)
      IDLE, DONE: if (bus.start) begin
        wb_n    = bus.wb_en;
        tile_n  = '0;
        k_n     = '0;
        state_n = LOAD;
      end
      LOAD:    if (&k) state_n = START; else k_n = k + 1'b1;
      START:   state_n = WAIT;
      WAIT:    if (bus.eng_done) begin
        state_n = wb ? WRITE : NEXT;
        k_n     = wb ? '0 : k;
      end
      WRITE:   if (&k) state_n = NEXT; else k_n = k + 1'b1;
      NEXT: begin
        state_n = &tile ? DONE : LOAD;
        tile_n  = &tile ? tile : tile + 1'b1;
        k_n     = '0;
      end
      default: state_n = IDLE;
    endcase
  end
  // k stays at its last value through START/WAIT/NEXT, so the address holds there
  assign act           = !(state inside {IDLE, DONE});
  assign bus.row       = act ? AW'({tile[TW-1:TB], k[KW-1:LT]}) : '0;
  assign bus.col       = act ? AW'({tile[TB-1:0], k[LT-1:0]}) : '0;
  assign bus.ld_en     = state == LOAD;
  assign bus.ld_idx    = state == LOAD ? k : '0;
  assign bus.eng_start = state == START;
  assign bus.out_we    = state == WRITE;
  assign bus.wb_idx    = state == WRITE ? k : '0;
  assign bus.tile_idx  = tile;
  assign bus.busy      = act;
  assign bus.done      = state == DONE;
endmodule

// File: tb/tb_tile_scan_ctrl.sv
// tb_tile_scan_ctrl: randomized scans against a queue-based scoreboard of expected load/write beats
module tb_tile_scan_ctrl;
  localparam int IMG = 64, TL = 4, AW = 6, KW = 4, TW = 8;
  localparam int TPR = IMG / TL, NT = TPR * TPR, KN = TL * TL;
  typedef struct {bit we; int row; int col; int idx; int tile;} ev_t;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  tile_scan_if #(.AW(AW), .KW(KW), .TW(TW)) bus();
  tile_scan_ctrl #(.IMG_DIM(IMG), .TILE(TL), .AW(AW), .KW(KW), .TW(TW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  ev_t exp_q[$];
  ev_t e;
  int checks = 0, errors = 0, cyc = 0, st0 = 0, st_cyc = 0, eng_w = 1;
  bit glitch = 0, cur_wb = 0, gap_pend = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask
  task automatic check_zero(string tag);
    chk({tag, "_row"}, bus.row, 0);
    chk({tag, "_col"}, bus.col, 0);
    chk({tag, "_ld_en"}, bus.ld_en, 0);
    chk({tag, "_ld_idx"}, bus.ld_idx, 0);
    chk({tag, "_eng_start"}, bus.eng_start, 0);
    chk({tag, "_out_we"}, bus.out_we, 0);
    chk({tag, "_wb_idx"}, bus.wb_idx, 0);
    chk({tag, "_tile_idx"}, bus.tile_idx, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
  endtask
  task automatic push_scan(bit wb);
    for (int t = 0; t < NT; t++)
      for (int p = 0; p < (wb ? 2 : 1); p++)
        for (int k = 0; k < KN; k++)
          exp_q.push_back('{p == 1, (t / TPR) * TL + k / TL, (t % TPR) * TL + k % TL, k, t});
  endtask
  // engine model: optional spurious eng_done during START, then eng_done on WAIT cycle eng_w
  initial begin
    bus.eng_done = 0;
    forever begin
      @(posedge clk); #1;
      if (bus.eng_start && rst_n) begin
        bus.eng_done = glitch;
        @(posedge clk); #1;
        bus.eng_done = (eng_w == 1);
        for (int i = 2; i <= eng_w; i++) begin
          @(posedge clk); #1;
          bus.eng_done = (i == eng_w);
        end
        @(posedge clk); #1;
        bus.eng_done = 0;
      end
    end
  end
  always @(negedge clk) if (rst_n) begin
    chk("strobe_excl", int'(bus.ld_en) + int'(bus.eng_start) + int'(bus.out_we) <= 1, 1);
    chk("busy_and_done", int'(bus.busy && bus.done), 0);
    if (bus.eng_start) begin
      st_cyc = cyc;
      gap_pend = 1;
    end
    if (bus.ld_en || bus.out_we) begin
      if (gap_pend) begin
        chk("wait_gap", cyc - st_cyc, cur_wb ? eng_w + 1 : eng_w + 2);
        gap_pend = 0;
      end
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe ld_en=%0d out_we=%0d row=%0d col=%0d want none", bus.ld_en, bus.out_we, bus.row, bus.col);
      end else begin
        e = exp_q.pop_front();
        chk("beat_we", bus.out_we, e.we);
        chk("beat_row", bus.row, e.row);
        chk("beat_col", bus.col, e.col);
        chk("beat_idx", bus.out_we ? bus.wb_idx : bus.ld_idx, e.idx);
        chk("beat_tile", bus.tile_idx, e.tile);
      end
    end
  end
  task automatic issue(bit wb, int w, bit g);
    eng_w = w;
    glitch = g;
    cur_wb = wb;
    gap_pend = 0;
    push_scan(wb);
    @(negedge clk);
    bus.start = 1;
    bus.wb_en = wb;
    @(negedge clk);
    bus.start = 0;
    bus.wb_en = 1'($urandom);
    st0 = cyc;
    chk("launch_ld_en", bus.ld_en, 1);
    chk("launch_done", bus.done, 0);
    chk("launch_busy", bus.busy, 1);
  endtask
  task automatic wait_done(bit wb, int w);
    int want = NT * (18 + w + 16 * int'(wb));
    int n = 0;
    while (!bus.done && n < want + 50) begin
      @(negedge clk);
      n++;
    end
    chk("done_level", bus.done, 1);
    chk("done_time", cyc - st0, want);
    chk("queue_drained", exp_q.size(), 0);
    chk("end_busy", bus.busy, 0);
    chk("end_row", bus.row, 0);
    chk("end_col", bus.col, 0);
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    bit wb;
    int w, n;
    bus.start = 0;
    bus.wb_en = 0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1;
    issue(1, 1, 0);
    wait_done(1, 1);
    issue(0, 1, 0);
    wait_done(0, 1);
    issue(1, 5, 1);
    repeat (100) @(negedge clk);
    bus.start = 1;
    bus.wb_en = 0;
    @(negedge clk);
    bus.start = 0;
    wait_done(1, 5);
    issue(1, 2, 0);
    n = 0;
    while (!(bus.out_we && bus.tile_idx == 40 && bus.wb_idx == 5) && n < 41 * 40) begin
      @(negedge clk);
      n++;
    end
    chk("reach_tile40_write", int'(bus.out_we && bus.tile_idx == 40), 1);
    rst_n = 0;
    @(negedge clk);
    check_zero("midscan_reset");
    exp_q.delete();
    gap_pend = 0;
    rst_n = 1;
    repeat (20) @(negedge clk);
    chk("post_reset_busy", bus.busy, 0);
    chk("post_reset_done", bus.done, 0);
    wb = 1'($urandom);
    w = int'($urandom_range(1, 4));
    issue(wb, w, 0);
    wait_done(wb, w);
    repeat (3) @(negedge clk);
    chk("done_holds", bus.done, 1);
    wb = 1'($urandom);
    w = int'($urandom_range(1, 4));
    issue(wb, w, 1'($urandom));
    wait_done(wb, w);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
